// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared types and helpers for the tree-router scheduler
package noc_pkg;

    typedef enum logic [1:0] {
        SRC_P   = 2'd0,
        SRC_CH1 = 2'd1,
        SRC_CH2 = 2'd2
    } src_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SEND   = 2'd2
    } state_e;

    // Widest packet / address the helper below can handle
    localparam int PKT_MAX  = 64;
    localparam int ADDR_MAX = 16;

    // Pull the receiver-address field out of a (zero-extended) packet
    function automatic logic [ADDR_MAX-1:0] get_rcv_addr(
        input logic [PKT_MAX-1:0] pkt,
        input int                 lsb,
        input int                 width
    );
        logic [PKT_MAX-1:0]  sh;
        logic [ADDR_MAX-1:0] a;
        sh = pkt >> lsb;
        a  = '0;
        for (int i = 0; i < ADDR_MAX; i++) begin
            if (i < width) begin
                a[i] = sh[i];
            end
        end
        return a;
    endfunction

    // Round-robin successor: parent -> ch1 -> ch2 -> parent
    function automatic src_e next_src(input src_e s);
        case (s)
            SRC_P:   return SRC_CH1;
            SRC_CH1: return SRC_CH2;
            default: return SRC_P;
        endcase
    endfunction

endpackage

// File: rtl/noc_rr_arb3.sv
// rtl/noc_rr_arb3.sv - three-way round-robin arbiter starting at a pointer
module noc_rr_arb3
    import noc_pkg::*;
(
    input  logic [2:0] req,
    input  src_e       ptr,
    output logic [2:0] gnt
);

    // First requester at or after the pointer wins; result is one-hot or zero
    always_comb begin
        gnt = 3'b000;
        case (ptr)
            SRC_P: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
            SRC_CH1: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            default: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
        endcase
    end

endmodule

// File: rtl/noc_route_sched.sv
// rtl/noc_route_sched.sv - round-robin scheduler and route engine for one tree router node
module noc_route_sched
    import noc_pkg::*;
#(
    parameter int ROUTER_ADD = 2,
    parameter int LEFT_MIN   = 1,
    parameter int RIGHT_MAX  = 13,
    parameter int WIDTH_PACK = 20,
    parameter int WIDTH_ADD  = 5,
    parameter int RCV_LSB    = 15,
    parameter int PACKDELAY  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_in_valid,
    input  logic                  ch1_in_valid,
    input  logic                  ch2_in_valid,
    input  logic [WIDTH_PACK-1:0] p_in_data,
    input  logic [WIDTH_PACK-1:0] ch1_in_data,
    input  logic [WIDTH_PACK-1:0] ch2_in_data,
    output logic                  p_in_ready,
    output logic                  ch1_in_ready,
    output logic                  ch2_in_ready,
    output logic                  p_out_valid,
    output logic                  ch1_out_valid,
    output logic                  ch2_out_valid,
    output logic [WIDTH_PACK-1:0] p_out_data,
    output logic [WIDTH_PACK-1:0] ch1_out_data,
    output logic [WIDTH_PACK-1:0] ch2_out_data,
    input  logic                  p_out_ready,
    input  logic                  ch1_out_ready,
    input  logic                  ch2_out_ready,
    output logic                  busy,
    output logic                  route_err,
    output logic [15:0]           fwd_count
);

    localparam logic [3:0] DLY_LOAD = (PACKDELAY > 0) ? 4'(PACKDELAY - 1) : 4'd0;
    localparam logic [ADDR_MAX-1:0] A_ROUTER = ADDR_MAX'(ROUTER_ADD);
    localparam logic [ADDR_MAX-1:0] A_LEFT   = ADDR_MAX'(LEFT_MIN);
    localparam logic [ADDR_MAX-1:0] A_RIGHT  = ADDR_MAX'(RIGHT_MAX);

    state_e                state;
    state_e                state_nxt;
    logic [3:0]            dly_cnt;
    src_e                  rr_ptr;
    src_e                  lat_src;
    src_e                  lat_dst;
    logic [WIDTH_PACK-1:0] lat_data;

    logic [2:0]            req;
    logic [2:0]            gnt;
    logic                  grant;
    logic                  load_send;
    logic                  handshake;
    src_e                  gnt_src;
    logic [WIDTH_PACK-1:0] gnt_data;

    src_e                  rt_src;
    logic [WIDTH_PACK-1:0] rt_data;
    logic [ADDR_MAX-1:0]   rcv;
    logic                  in_range;
    src_e                  rt_dst;
    logic                  rt_err;
    logic                  sel_ready;

    assign req = {ch2_in_valid, ch1_in_valid, p_in_valid};

    noc_rr_arb3 u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    // Identify the granted source and its head packet
    always_comb begin
        gnt_src  = SRC_P;
        gnt_data = p_in_data;
        if (gnt[1]) begin
            gnt_src  = SRC_CH1;
            gnt_data = ch1_in_data;
        end else if (gnt[2]) begin
            gnt_src  = SRC_CH2;
            gnt_data = ch2_in_data;
        end
    end

    // Route decode: the packet being granted in IDLE, otherwise the latched one
    always_comb begin
        rt_src   = (state == IDLE) ? gnt_src  : lat_src;
        rt_data  = (state == IDLE) ? gnt_data : lat_data;
        rcv      = get_rcv_addr(PKT_MAX'(rt_data), RCV_LSB, WIDTH_ADD);
        in_range = (rcv >= A_LEFT) && (rcv <= A_RIGHT);
        rt_dst   = SRC_P;
        rt_err   = 1'b0;
        case (rt_src)
            SRC_P: begin
                rt_dst = (rcv > A_ROUTER) ? SRC_CH2 : SRC_CH1;
                rt_err = !in_range;
            end
            SRC_CH1: rt_dst = in_range ? SRC_CH2 : SRC_P;
            default: rt_dst = in_range ? SRC_CH1 : SRC_P;
        endcase
    end

    // Only the port selected for the current packet can complete the handshake
    always_comb begin
        case (lat_dst)
            SRC_P:   sel_ready = p_out_valid   & p_out_ready;
            SRC_CH1: sel_ready = ch1_out_valid & ch1_out_ready;
            default: sel_ready = ch2_out_valid & ch2_out_ready;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle strobes
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        load_send = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE: begin
                if ((|gnt) && !rst) begin
                    grant = 1'b1;
                    if (PACKDELAY == 0) begin
                        state_nxt = SEND;
                        load_send = 1'b1;
                    end else begin
                        state_nxt = DECODE;
                    end
                end
            end
            DECODE: begin
                if (dly_cnt == 4'd0) begin
                    state_nxt = SEND;
                    load_send = 1'b1;
                end
            end
            SEND: begin
                if (sel_ready) begin
                    state_nxt = IDLE;
                    handshake = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign p_in_ready   = grant & gnt[0];
    assign ch1_in_ready = grant & gnt[1];
    assign ch2_in_ready = grant & gnt[2];
    assign busy         = (state != IDLE);

    // Packet latch, delay counter, output registers, pointer and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_cnt       <= 4'd0;
            rr_ptr        <= SRC_P;
            lat_src       <= SRC_P;
            lat_dst       <= SRC_P;
            lat_data      <= '0;
            p_out_valid   <= 1'b0;
            ch1_out_valid <= 1'b0;
            ch2_out_valid <= 1'b0;
            p_out_data    <= '0;
            ch1_out_data  <= '0;
            ch2_out_data  <= '0;
            route_err     <= 1'b0;
            fwd_count     <= 16'd0;
        end else begin
            route_err <= 1'b0;
            if (grant) begin
                lat_data  <= gnt_data;
                lat_src   <= gnt_src;
                lat_dst   <= rt_dst;
                dly_cnt   <= DLY_LOAD;
                route_err <= rt_err;
            end else if ((state == DECODE) && (dly_cnt != 4'd0)) begin
                dly_cnt <= dly_cnt - 4'd1;
            end
            if (load_send) begin
                case (rt_dst)
                    SRC_P: begin
                        p_out_valid <= 1'b1;
                        p_out_data  <= rt_data;
                    end
                    SRC_CH1: begin
                        ch1_out_valid <= 1'b1;
                        ch1_out_data  <= rt_data;
                    end
                    default: begin
                        ch2_out_valid <= 1'b1;
                        ch2_out_data  <= rt_data;
                    end
                endcase
            end
            if (handshake) begin
                p_out_valid   <= 1'b0;
                ch1_out_valid <= 1'b0;
                ch2_out_valid <= 1'b0;
                rr_ptr        <= next_src(lat_src);
                if (fwd_count != 16'hFFFF) begin
                    fwd_count <= fwd_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_route_sched.sv
// tb/tb_noc_route_sched.sv - directed self-checking bench for noc_route_sched
module tb_noc_route_sched;

    localparam int WP = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    iv;
    logic [2:0]    ordy;
    logic [WP-1:0] id0, id1, id2;
    logic [2:0]    ir;
    logic [2:0]    ov;
    logic [WP-1:0] od0, od1, od2;
    logic          busy;
    logic          route_err;
    logic [15:0]   fwd_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    // Free-running cycle index used to measure grant spacing
    always @(posedge clk) cyc <= cyc + 1;

    noc_route_sched #(
        .ROUTER_ADD (2),
        .LEFT_MIN   (1),
        .RIGHT_MAX  (13),
        .WIDTH_PACK (WP),
        .WIDTH_ADD  (5),
        .RCV_LSB    (15),
        .PACKDELAY  (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .p_in_valid    (iv[0]),
        .ch1_in_valid  (iv[1]),
        .ch2_in_valid  (iv[2]),
        .p_in_data     (id0),
        .ch1_in_data   (id1),
        .ch2_in_data   (id2),
        .p_in_ready    (ir[0]),
        .ch1_in_ready  (ir[1]),
        .ch2_in_ready  (ir[2]),
        .p_out_valid   (ov[0]),
        .ch1_out_valid (ov[1]),
        .ch2_out_valid (ov[2]),
        .p_out_data    (od0),
        .ch1_out_data  (od1),
        .ch2_out_data  (od2),
        .p_out_ready   (ordy[0]),
        .ch1_out_ready (ordy[1]),
        .ch2_out_ready (ordy[2]),
        .busy          (busy),
        .route_err     (route_err),
        .fwd_count     (fwd_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WP-1:0] mkpkt(input int rcv, input int pay);
        return {5'(rcv), 15'(pay)};
    endfunction

    function automatic logic [WP-1:0] od_of(input int p);
        case (p)
            0:       return od0;
            1:       return od1;
            default: return od2;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int s, input logic [WP-1:0] d);
        case (s)
            0:       id0 = d;
            1:       id1 = d;
            default: id2 = d;
        endcase
        iv[s] = 1'b1;
    endtask

    // One packet end to end with out_ready held high
    task automatic send_one(input string tag, input int src, input int rcv, input int pay,
                            input int dst, input int err);
        logic [WP-1:0] pk;
        logic [15:0]   f0;
        pk = mkpkt(rcv, pay);
        f0 = fwd_count;
        iv = 3'b000;
        set_in(src, pk);
        #1;
        chk({tag, "_in_ready"}, 32'(ir), 32'(3'b001 << src));
        step();
        iv = 3'b000;
        chk({tag, "_route_err"}, 32'(route_err), 32'(err));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_no_early_valid"}, 32'(ov), 32'd0);
        step();
        chk({tag, "_out_valid"}, 32'(ov), 32'(3'b001 << dst));
        chk({tag, "_out_data"}, 32'(od_of(dst)), 32'(pk));
        chk({tag, "_err_pulse_end"}, 32'(route_err), 32'd0);
        step();
        chk({tag, "_valid_drop"}, 32'(ov), 32'd0);
        chk({tag, "_fwd_count"}, 32'(fwd_count), 32'(f0 + 16'd1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [6];
        int last;
        int n;
        exp_order = '{0, 1, 2, 0, 1, 2};

        rst  = 1'b1;
        iv   = 3'b111;
        ordy = 3'b111;
        id0  = mkpkt(3, 1);
        id1  = mkpkt(3, 2);
        id2  = mkpkt(3, 3);

        // Reset held two cycles with every queue requesting
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_in_ready", 32'(ir), 32'd0);
            chk("rst_out_valid", 32'(ov), 32'd0);
            chk("rst_fwd_count", 32'(fwd_count), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        iv  = 3'b000;
        rst = 1'b0;
        step();

        // Route decisions, including range boundaries
        send_one("p_rcv5",    0, 5,  'h0a1, 2, 0);
        send_one("p_rcv2",    0, 2,  'h0a2, 1, 0);
        send_one("p_rcv20",   0, 20, 'h0a3, 2, 1);
        send_one("p_rcv0",    0, 0,  'h0a4, 1, 1);
        send_one("c1_rcv14",  1, 14, 'h0b1, 0, 0);
        send_one("c2_rcv0",   2, 0,  'h0c1, 0, 0);
        send_one("c2_rcv1",   2, 1,  'h0c2, 1, 0);
        send_one("c1_rcv13",  1, 13, 'h0b2, 2, 0);
        send_one("c1_rcv0",   1, 0,  'h0b3, 0, 0);

        // Fresh reset so the pointer starts at parent
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_fwd_count", 32'(fwd_count), 32'd0);

        // All three queues requesting: rotation and one packet per three cycles
        id0  = mkpkt(5, 'h100);
        id1  = mkpkt(14, 'h200);
        id2  = mkpkt(1, 'h300);
        iv   = 3'b111;
        last = 0;
        #1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (ir == 3'b000 && n < 8) begin
                step();
                n++;
            end
            chk("rr_grant", 32'(ir), 32'(3'b001 << exp_order[k]));
            if (k > 0) chk("rr_gap", 32'(cyc - last), 32'd3);
            last = cyc;
            step();
        end
        iv = 3'b000;
        step();
        step();
        chk("rr_fwd_count", 32'(fwd_count), 32'd6);
        chk("rr_idle", 32'(busy), 32'd0);

        // Backpressure on ch2 while ch1 waits
        ordy[2] = 1'b0;
        set_in(0, mkpkt(5, 'h1234));
        #1;
        chk("bp_p_ready", 32'(ir), 32'b001);
        step();
        iv = 3'b000;
        set_in(1, mkpkt(13, 'h0555));
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid_hold", 32'(ov), 32'b100);
            chk("bp_data_hold", 32'(od2), 32'(mkpkt(5, 'h1234)));
            chk("bp_no_in_ready", 32'(ir), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            step();
        end
        ordy[2] = 1'b1;
        step();
        chk("bp_release_valid", 32'(ov), 32'd0);
        chk("bp_next_grant", 32'(ir), 32'b010);
        step();
        iv = 3'b000;
        step();
        chk("bp_c1_out_valid", 32'(ov), 32'b100);
        chk("bp_c1_out_data", 32'(od2), 32'(mkpkt(13, 'h0555)));
        step();
        chk("bp_fwd_count", 32'(fwd_count), 32'd8);

        // Reset in the middle of SEND drops the packet and rewinds the pointer
        ordy[1] = 1'b0;
        set_in(2, mkpkt(1, 'h0777));
        #1;
        chk("mid_c2_ready", 32'(ir), 32'b100);
        step();
        iv = 3'b000;
        step();
        chk("mid_send_valid", 32'(ov), 32'b010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(ov), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fwd", 32'(fwd_count), 32'd0);
        ordy = 3'b111;
        iv   = 3'b111;
        #1;
        chk("mid_rst_ptr_parent", 32'(ir), 32'b001);
        step();
        iv = 3'b000;
        step();
        step();
        chk("post_rst_fwd", 32'(fwd_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
